// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/load-store memory port arbiter.
// The owner enum is also used by the pipeline top and hazard unit for debug.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between F-stage fetch and M-stage load/store.
// One transaction at a time; data wins unless fetch has waited MAX_D_STREAK data grants.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                reset_x,
  input  logic                Fi_req,
  input  logic [ADDR_W-1:0]   Fi_addr,
  input  logic                Fi_flush,
  input  logic                Mi_req,
  input  logic                Mi_we,
  input  logic [ADDR_W-1:0]   Mi_addr,
  input  logic [DATA_W-1:0]   Mi_wdata,
  input  logic [DATA_W/8-1:0] Mi_be,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [DATA_W-1:0]   Fo_rdata,
  output logic                Fo_valid,
  output logic [DATA_W-1:0]   Mo_rdata,
  output logic                Mo_valid,
  output logic                Fo_stall,
  output logic                Mo_stall
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  arb_state_t          state_q, state_d;
  logic [STREAK_W-1:0] streak_q;
  logic                drop_q;
  logic                elig_f, elig_d;
  logic                grant, done;
  owner_t              grant_own;

  // A requester whose valid is pulsing this cycle has already been served.
  assign elig_f = Fi_req & ~Fo_valid & ~Fi_flush;
  assign elig_d = Mi_req & ~Mo_valid;

  assign Fo_stall = Fi_req & ~Fo_valid;
  assign Mo_stall = Mi_req & ~Mo_valid;

  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    grant_own = OWN_I;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (elig_d && !(elig_f && (streak_q == STREAK_MAX))) begin
          grant     = 1'b1;
          grant_own = OWN_D;
          state_d   = BUSY_D;
        end else if (elig_f) begin
          grant     = 1'b1;
          grant_own = OWN_I;
          state_d   = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      Fo_rdata  <= '0;
      Fo_valid  <= 1'b0;
      Mo_rdata  <= '0;
      Mo_valid  <= 1'b0;
      drop_q    <= 1'b0;
      streak_q  <= '0;
    end else begin
      Fo_valid <= 1'b0;
      Mo_valid <= 1'b0;

      if (grant) begin
        mem_req <= 1'b1;
        if (grant_own == OWN_D) begin
          mem_we    <= Mi_we;
          mem_addr  <= Mi_addr;
          mem_wdata <= Mi_wdata;
          mem_be    <= Mi_be;
          if (!elig_f) begin
            streak_q <= '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_q <= streak_q + 1'b1;
          end
        end else begin
          mem_we    <= 1'b0;
          mem_addr  <= Fi_addr;
          mem_be    <= '1;
          streak_q  <= '0;
        end
      end

      // A flush landing on the return cycle also discards the instruction.
      if (state_q == BUSY_I) begin
        if (done) begin
          drop_q <= 1'b0;
          if (!(drop_q || Fi_flush)) begin
            Fo_rdata <= mem_rdata;
            Fo_valid <= 1'b1;
          end
        end else if (Fi_flush) begin
          drop_q <= 1'b1;
        end
      end

      if ((state_q == BUSY_D) && done) begin
        Mo_rdata <= mem_rdata;
        Mo_valid <= 1'b1;
      end

      if (done) begin
        mem_req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, priority, starvation cap, flush,
// store byte enables and asynchronous reset.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset_x;
  logic        Fi_req;
  logic [31:0] Fi_addr;
  logic        Fi_flush;
  logic        Mi_req;
  logic        Mi_we;
  logic [31:0] Mi_addr;
  logic [31:0] Mi_wdata;
  logic [3:0]  Mi_be;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] Fo_rdata;
  logic        Fo_valid;
  logic [31:0] Mo_rdata;
  logic        Mo_valid;
  logic        Fo_stall;
  logic        Mo_stall;

  int n_chk = 0;
  int n_err = 0;

  mem_port_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .MAX_D_STREAK(4)
  ) dut (
    .clk      (clk),
    .reset_x  (reset_x),
    .Fi_req   (Fi_req),
    .Fi_addr  (Fi_addr),
    .Fi_flush (Fi_flush),
    .Mi_req   (Mi_req),
    .Mi_we    (Mi_we),
    .Mi_addr  (Mi_addr),
    .Mi_wdata (Mi_wdata),
    .Mi_be    (Mi_be),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be   (mem_be),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .Fo_rdata (Fo_rdata),
    .Fo_valid (Fo_valid),
    .Mo_rdata (Mo_rdata),
    .Mo_valid (Mo_valid),
    .Fo_stall (Fo_stall),
    .Mo_stall (Mo_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until mem_req rises (bounded); any flush pulse lasts one cycle.
  task automatic wait_req(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step();
      Fi_flush = 1'b0;
      if (mem_req) seen = 1'b1;
    end
    chk(tag, 64'(seen), 64'(1));
  endtask

  logic [31:0] exp_addr   [7];
  logic        exp_we     [7];
  logic [3:0]  exp_streak [7];
  int          st_idx;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_x   = 1'b0;
    Fi_req    = 1'b0;
    Fi_addr   = '0;
    Fi_flush  = 1'b0;
    Mi_req    = 1'b0;
    Mi_we     = 1'b0;
    Mi_addr   = '0;
    Mi_wdata  = '0;
    Mi_be     = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;

    // Reset state
    step();
    step();
    chk("rst_mem_req",  64'(mem_req),  64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_be",   64'(mem_be),   64'(0));
    chk("rst_fo_valid", 64'(Fo_valid), 64'(0));
    chk("rst_mo_valid", 64'(Mo_valid), 64'(0));
    chk("rst_fo_rdata", 64'(Fo_rdata), 64'(0));
    chk("rst_streak",   64'(dut.streak_q), 64'(0));
    reset_x = 1'b1;
    step();

    // Single fetch, memory ready on the third busy cycle
    Fi_req  = 1'b1;
    Fi_addr = 32'h100;
    #1;
    chk("f1_stall_t0", 64'(Fo_stall), 64'(1));
    chk("f1_req_t0",   64'(mem_req),  64'(0));
    step();
    chk("f1_req_t1",   64'(mem_req),  64'(1));
    chk("f1_addr",     64'(mem_addr), 64'(32'h100));
    chk("f1_we",       64'(mem_we),   64'(0));
    chk("f1_be",       64'(mem_be),   64'(4'hF));
    chk("f1_stall_t1", 64'(Fo_stall), 64'(1));
    step();
    chk("f1_req_t2",   64'(mem_req),  64'(1));
    step();
    mem_ready = 1'b1;
    mem_rdata = 32'h0050_0093;
    chk("f1_req_t3",   64'(mem_req),  64'(1));
    chk("f1_stall_t3", 64'(Fo_stall), 64'(1));
    step();
    mem_ready = 1'b0;
    chk("f1_valid",    64'(Fo_valid), 64'(1));
    chk("f1_rdata",    64'(Fo_rdata), 64'(32'h0050_0093));
    chk("f1_stall_t4", 64'(Fo_stall), 64'(0));
    chk("f1_req_t4",   64'(mem_req),  64'(0));
    Fi_req = 1'b0;
    step();
    chk("f1_valid_pulse", 64'(Fo_valid), 64'(0));

    // Simultaneous fetch and load: load first
    Fi_req  = 1'b1;
    Fi_addr = 32'h104;
    Mi_req  = 1'b1;
    Mi_we   = 1'b0;
    Mi_addr = 32'h2000;
    Mi_be   = 4'hF;
    step();
    chk("sim_d_req",  64'(mem_req),  64'(1));
    chk("sim_d_addr", 64'(mem_addr), 64'(32'h2000));
    chk("sim_d_we",   64'(mem_we),   64'(0));
    chk("sim_streak1", 64'(dut.streak_q), 64'(1));
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE_0001;
    step();
    mem_ready = 1'b0;
    chk("sim_mo_valid", 64'(Mo_valid), 64'(1));
    chk("sim_mo_rdata", 64'(Mo_rdata), 64'(32'hCAFE_0001));
    chk("sim_fo_stall", 64'(Fo_stall), 64'(1));
    chk("sim_req_gap",  64'(mem_req),  64'(0));
    Mi_req = 1'b0;
    step();
    chk("sim_f_req",  64'(mem_req),  64'(1));
    chk("sim_f_addr", 64'(mem_addr), 64'(32'h104));
    chk("sim_streak0", 64'(dut.streak_q), 64'(0));
    mem_ready = 1'b1;
    mem_rdata = 32'h0000_0013;
    step();
    mem_ready = 1'b0;
    chk("sim_fo_valid", 64'(Fo_valid), 64'(1));
    chk("sim_fo_rdata", 64'(Fo_rdata), 64'(32'h0000_0013));
    Fi_req = 1'b0;
    step();

    // Starvation cap: fetch held, six stores; a flush in each store's
    // return cycle keeps the fetch out of the gap until the cap forces it.
    for (int k = 0; k < 4; k++) begin
      exp_addr[k]   = 32'h3000 + 32'(k * 4);
      exp_we[k]     = 1'b1;
      exp_streak[k] = 4'(k + 1);
    end
    exp_addr[4] = 32'h400;  exp_we[4] = 1'b0; exp_streak[4] = 4'd0;
    exp_addr[5] = 32'h3010; exp_we[5] = 1'b1; exp_streak[5] = 4'd0;
    exp_addr[6] = 32'h3014; exp_we[6] = 1'b1; exp_streak[6] = 4'd0;

    st_idx   = 0;
    Fi_req   = 1'b1;
    Fi_addr  = 32'h400;
    Mi_req   = 1'b1;
    Mi_we    = 1'b1;
    Mi_addr  = 32'h3000;
    Mi_wdata = 32'h5000_0000;
    Mi_be    = 4'hF;
    for (int g = 0; g < 7; g++) begin
      wait_req($sformatf("stv_wait%0d", g));
      chk($sformatf("stv_addr%0d", g),   64'(mem_addr), 64'(exp_addr[g]));
      chk($sformatf("stv_we%0d", g),     64'(mem_we),   64'(exp_we[g]));
      chk($sformatf("stv_streak%0d", g), 64'(dut.streak_q), 64'(exp_streak[g]));
      mem_ready = 1'b1;
      mem_rdata = 32'h1000 + 32'(g);
      step();
      mem_ready = 1'b0;
      if (exp_we[g]) begin
        chk($sformatf("stv_mo_valid%0d", g), 64'(Mo_valid), 64'(1));
        st_idx++;
        if (st_idx < 6) begin
          Mi_addr  = 32'h3000 + 32'(st_idx * 4);
          Mi_wdata = 32'h5000_0000 + 32'(st_idx);
        end else begin
          Mi_req = 1'b0;
        end
        if (g < 4) Fi_flush = 1'b1;
      end else begin
        chk("stv_fo_valid", 64'(Fo_valid), 64'(1));
        chk("stv_fo_rdata", 64'(Fo_rdata), 64'(32'h1004));
        Fi_req = 1'b0;
      end
    end
    step();
    Fi_flush = 1'b0;
    chk("stv_idle", 64'(mem_req), 64'(0));

    // Flush during an in-flight fetch
    Fi_req  = 1'b1;
    Fi_addr = 32'h200;
    step();
    chk("fl_req",  64'(mem_req),  64'(1));
    chk("fl_addr", 64'(mem_addr), 64'(32'h200));
    Fi_flush = 1'b1;
    step();
    Fi_flush  = 1'b0;
    Fi_addr   = 32'h300;
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    chk("fl_addr_stable", 64'(mem_addr), 64'(32'h200));
    chk("fl_drop_set",    64'(dut.drop_q), 64'(1));
    step();
    mem_ready = 1'b0;
    chk("fl_no_valid",    64'(Fo_valid), 64'(0));
    chk("fl_rdata_kept",  64'(Fo_rdata), 64'(32'h1004));
    chk("fl_drop_clear",  64'(dut.drop_q), 64'(0));
    step();
    chk("fl2_req",  64'(mem_req),  64'(1));
    chk("fl2_addr", 64'(mem_addr), 64'(32'h300));
    mem_ready = 1'b1;
    mem_rdata = 32'h0000_0297;
    step();
    mem_ready = 1'b0;
    chk("fl2_valid", 64'(Fo_valid), 64'(1));
    chk("fl2_rdata", 64'(Fo_rdata), 64'(32'h0000_0297));
    Fi_req = 1'b0;
    step();

    // Store with partial byte enables, two-cycle memory
    Mi_req   = 1'b1;
    Mi_we    = 1'b1;
    Mi_addr  = 32'h2004;
    Mi_wdata = 32'h1234_ABCD;
    Mi_be    = 4'b0011;
    step();
    chk("st_req",   64'(mem_req),   64'(1));
    chk("st_we",    64'(mem_we),    64'(1));
    chk("st_be",    64'(mem_be),    64'(4'b0011));
    chk("st_addr",  64'(mem_addr),  64'(32'h2004));
    chk("st_wdata", 64'(mem_wdata), 64'(32'h1234_ABCD));
    chk("st_mo_stall", 64'(Mo_stall), 64'(1));
    step();
    chk("st_wdata_hold", 64'(mem_wdata), 64'(32'h1234_ABCD));
    chk("st_no_valid",   64'(Mo_valid),  64'(0));
    mem_ready = 1'b1;
    mem_rdata = 32'h0;
    step();
    mem_ready = 1'b0;
    chk("st_valid",    64'(Mo_valid), 64'(1));
    chk("st_mo_stall0", 64'(Mo_stall), 64'(0));
    Mi_req = 1'b0;
    step();
    chk("st_valid_pulse", 64'(Mo_valid), 64'(0));
    chk("st_idle",        64'(mem_req),  64'(0));

    // Asynchronous reset during a load
    Mi_req  = 1'b1;
    Mi_we   = 1'b0;
    Mi_addr = 32'h2008;
    Mi_be   = 4'hF;
    step();
    chk("ar_busy", 64'(mem_req), 64'(1));
    #2;
    reset_x = 1'b0;
    #1;
    chk("ar_req",      64'(mem_req),  64'(0));
    chk("ar_addr",     64'(mem_addr), 64'(0));
    chk("ar_fo_rdata", 64'(Fo_rdata), 64'(0));
    chk("ar_state",    64'(dut.state_q), 64'(0));
    Mi_req = 1'b0;
    step();
    reset_x = 1'b1;
    step();
    Fi_req  = 1'b1;
    Fi_addr = 32'h500;
    step();
    chk("ar_f_req",  64'(mem_req),  64'(1));
    chk("ar_f_addr", 64'(mem_addr), 64'(32'h500));
    mem_ready = 1'b1;
    mem_rdata = 32'h0010_0073;
    step();
    mem_ready = 1'b0;
    chk("ar_f_valid", 64'(Fo_valid), 64'(1));
    chk("ar_f_rdata", 64'(Fo_rdata), 64'(32'h0010_0073));
    Fi_req = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port instruction/data memory between the F-stage instruction fetch and the M-stage load/store of the 5-stage RISC-V pipeline. It sequences one memory transaction at a time over a variable-latency ready handshake. It returns read data to the requester and raises per-stage stall requests, which the hazard logic ORs into the existing F/D stalls. Data accesses normally win; a streak counter bounds fetch starvation.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_D_STREAK, 4, consecutive data grants allowed while a fetch is eligible before fetch is forced (range 1..15)

Ports:
clk  in  1  clock; all state updates on rising edge
reset_x  in  1  asynchronous, active-low reset
Fi_req  in  1  fetch request; held with Fi_addr until Fo_valid
Fi_addr  in  ADDR_W  fetch address
Fi_flush  in  1  discard the in-flight or pending fetch (branch/jump taken)
Mi_req  in  1  load/store request; held with its fields until Mo_valid
Mi_we  in  1  1 = store
Mi_addr  in  ADDR_W  data address
Mi_wdata  in  DATA_W  store data
Mi_be  in  DATA_W/8  byte enables
mem_req  out  1  memory transaction active
mem_we  out  1  write
mem_addr  out  ADDR_W  address
mem_wdata  out  DATA_W  write data
mem_be  out  DATA_W/8  byte enables
mem_ready  in  1  transaction complete; mem_rdata valid this cycle
mem_rdata  in  DATA_W  read data
Fo_rdata  out  DATA_W  fetched instruction (registered)
Fo_valid  out  1  one-cycle pulse: Fo_rdata valid
Mo_rdata  out  DATA_W  load data (registered)
Mo_valid  out  1  one-cycle pulse: load/store done
Fo_stall  out  1  Fi_req & ~Fo_valid
Mo_stall  out  1  Mi_req & ~Mo_valid

Behaviour:
- Reset (reset_x=0, async): state IDLE; mem_req, mem_we, Fo_valid, Mo_valid, drop flag and streak count are 0; mem_addr, mem_wdata, mem_be, Fo_rdata, Mo_rdata are 0. An abandoned memory transaction is not resumed; memory must tolerate mem_req dropping.
- FSM states: IDLE, BUSY_I, BUSY_D.
- Arbitration happens only in IDLE.
  - eligF = Fi_req & ~Fo_valid & ~Fi_flush.
  - eligD = Mi_req & ~Mo_valid.
  - Grant D if eligD and not (eligF and streak == MAX_D_STREAK). Otherwise grant F if eligF. Otherwise stay IDLE.
- On a grant, next cycle: state BUSY_x; mem_req=1; mem_* latched from the winner (mem_we=0, mem_be all ones for fetch). mem_* stay stable until mem_ready.
- In BUSY_x with mem_ready=1: next cycle is IDLE; mem_req=0; the owning requester's rdata register loads mem_rdata; its valid pulses for exactly one cycle. Stores also pulse Mo_valid; Mo_rdata is then don't-care.
- Minimum latency: request at cycle t, mem_ready at t+1, valid at t+2. Back-to-back: a new grant is possible in the valid cycle (IDLE), so mem_req restarts at t+3.
- Streak counter (4 bits, saturating at MAX_D_STREAK):
  - +1 on a D grant while eligF.
  - Cleared on an F grant, and on a D grant with ~eligF.
- Flush:
  - Fi_flush in BUSY_I sets drop. At mem_ready, Fo_valid stays 0 and Fo_rdata is unchanged; drop clears on that return.
  - Fi_flush in the same cycle as a fetch Fo_valid does not suppress the pulse.
  - Fi_flush never affects data transactions.
- Simultaneous eligF and eligD in IDLE with streak < MAX: D wins; F waits, with Fo_stall held.
- Stall outputs are combinational from inputs and registered valid; no combinational path from mem_ready.

Decomposition:
- Shared package: FSM state encoding (IDLE/BUSY_I/BUSY_D, 2 bits) and a grant-owner enum (OWN_I, OWN_D). The pipeline top and the hazard unit reuse the owner enum for debug.
- No sub-module; the FSM, streak counter and output registers stay in one module.

Test Plan:
- Single fetch: Fi_req, Fi_addr=0x100, mem_ready at t+3 with rdata 0x00500093 -> mem_req t+1..t+3, addr 0x100; Fo_valid at t+4 with Fo_rdata=0x00500093; Fo_stall 1 for t..t+3.
- Simultaneous: Fi_req(0x104) and Mi_req load 0x2000 at t, 1-cycle memory -> data first (Mo_valid t+2); fetch mem_req at t+3, Fo_valid t+4.
- Starvation: Fi_req held, 6 back-to-back stores, MAX_D_STREAK=4 -> four data grants, then fetch granted, then remaining stores; streak reads 0 after the fetch grant.
- Flush mid-fetch: fetch 0x200 in BUSY_I, Fi_flush pulse, mem_ready with 0xDEADBEEF -> Fo_valid stays 0, Fo_rdata unchanged; next fetch 0x300 completes normally.
- Store byte enables: Mi_we=1, Mi_be=0b0011, Mi_wdata=0x1234ABCD, addr 0x2004 -> mem_we=1, mem_be=0b0011, mem_wdata held until mem_ready; Mo_valid one pulse.
- Reset mid-op: reset_x low during BUSY_D -> mem_req 0 immediately (async), all outputs 0; after release a new fetch completes with normal latency.
